// File: rtl/bitsel_pkg.sv
// rtl/bitsel_pkg.sv - sizing helpers shared by the pipelined bit selector
package bitsel_pkg;

  // Default geometry: the 32:1 selector split into two-level register slices.
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_LANES       = 1;
  localparam int DEF_LVL_PER_STG = 2;

  // Smallest r with 2**r >= v; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Ceiling division for positive operands.
  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Number of candidates one slice folds into a single bit.
  function automatic int pow2(input int n);
    return 1 << n;
  endfunction

  // Select-index width for a lane word.
  function automatic int sel_w(input int width);
    return clog2(width);
  endfunction

  // Register slices needed to resolve every select bit.
  function automatic int stages(input int width, input int lvl_per_stg);
    return cdiv(clog2(width), lvl_per_stg);
  endfunction

  // Tree levels resolved by slice s; the last slice may take fewer.
  function automatic int stage_lvls(input int width, input int lvl_per_stg, input int s);
    int left;
    left = clog2(width) - s * lvl_per_stg;
    return (left < lvl_per_stg) ? left : lvl_per_stg;
  endfunction

endpackage

// File: rtl/bitsel_stage.sv
// rtl/bitsel_stage.sv - one register slice of the radix-2 select tree
module bitsel_stage
  import bitsel_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int LVLS = 2,
  parameter int SW   = 2,
  localparam int OUT_W = IN_W >> LVLS,
  localparam int SWO_W = (SW > LVLS) ? (SW - LVLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [IN_W-1:0]  cand_i,
  input  logic [SW-1:0]    sel_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] cand_o,
  output logic [SWO_W-1:0] sel_o
);

  localparam int GRP = pow2(LVLS);

  logic [LVLS-1:0]  sel_lo;
  logic [OUT_W-1:0] cand_d;
  logic [SWO_W-1:0] sel_d;
  logic [OUT_W-1:0] cand_q;
  logic [SWO_W-1:0] sel_q;
  logic             valid_q;

  // The low LVLS select bits resolve LVLS tree levels at once: each group of
  // GRP adjacent candidates collapses to the one they address.
  assign sel_lo = sel_i[LVLS-1:0];

  for (genvar o = 0; o < OUT_W; o++) begin : g_grp
    logic [GRP-1:0] grp;
    assign grp       = cand_i[o*GRP +: GRP];
    assign cand_d[o] = grp[sel_lo];
  end

  // Bits not yet consumed ride along; the final slice carries a zero filler.
  if (SW > LVLS) begin : g_sel_shift
    assign sel_d = sel_i[SW-1:LVLS];
  end else begin : g_sel_done
    assign sel_d = '0;
  end

  // Slice register: loads only on the shared pipeline advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      cand_q  <= '0;
      sel_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      cand_q  <= cand_d;
      sel_q   <= sel_d;
    end
  end

  assign valid_o = valid_q;
  assign cand_o  = cand_q;
  assign sel_o   = sel_q;

endmodule

// File: rtl/bitsel_pipe.sv
// rtl/bitsel_pipe.sv - pipelined multi-lane single-bit selector with valid/ready
module bitsel_pipe
  import bitsel_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int LANES       = DEF_LANES,
  parameter int LVL_PER_STG = DEF_LVL_PER_STG
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WIDTH-1:0]        in_data,
  input  logic [LANES*sel_w(WIDTH)-1:0] in_sel,
  input  logic                          in_rev,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0]              out_bit
);

  localparam int SEL_W  = sel_w(WIDTH);
  localparam int STAGES = stages(WIDTH, LVL_PER_STG);

  logic             adv;
  logic [LANES-1:0] lane_valid;

  // One global enable: the whole pipe moves together, so bubbles are kept
  // and every lane's valid chain stays identical.
  assign out_valid = &lane_valid;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv & ~rst;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    for (genvar s = 0; s < STAGES; s++) begin : g_stg
      localparam int LO  = s * LVL_PER_STG;
      localparam int LV  = stage_lvls(WIDTH, LVL_PER_STG, s);
      localparam int IW  = WIDTH >> LO;
      localparam int SWI = SEL_W - LO;
      localparam int OW  = IW >> LV;
      localparam int SWO = (SWI > LV) ? (SWI - LV) : 1;

      logic           valid_in;
      logic [IW-1:0]  cand_in;
      logic [SWI-1:0] sel_in;
      logic           valid_q;
      logic [OW-1:0]  cand_q;
      logic [SWO-1:0] sel_q;

      if (s == 0) begin : g_head
        // MSB-first indexing is just the one's complement of the index,
        // applied before the tree so it costs no latency.
        assign valid_in = in_valid;
        assign cand_in  = in_data[k*WIDTH +: WIDTH];
        assign sel_in   = in_sel[k*SEL_W +: SEL_W] ^ {SEL_W{in_rev}};
      end else begin : g_body
        assign valid_in = g_stg[s-1].valid_q;
        assign cand_in  = g_stg[s-1].cand_q;
        assign sel_in   = g_stg[s-1].sel_q;
      end

      bitsel_stage #(
        .IN_W (IW),
        .LVLS (LV),
        .SW   (SWI)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en_i    (adv),
        .valid_i (valid_in),
        .cand_i  (cand_in),
        .sel_i   (sel_in),
        .valid_o (valid_q),
        .cand_o  (cand_q),
        .sel_o   (sel_q)
      );
    end

    // Last slice holds exactly one candidate: the selected bit, straight from a flop.
    assign out_bit[k]    = g_stg[STAGES-1].cand_q[0];
    assign lane_valid[k] = g_stg[STAGES-1].valid_q;

    logic lane_unused_sel;
    assign lane_unused_sel = ^g_stg[STAGES-1].sel_q;
  end

endmodule

// File: tb/tb_bitsel_pipe.sv
// tb/tb_bitsel_pipe.sv - self-checking bench for bitsel_pipe
module tb_bitsel_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   total;
  int   bad;
  logic sweep_go;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- main instance: WIDTH=32, LANES=1, LVL_PER_STG=2 ----------------
  logic        m_rst, m_in_valid, m_in_ready, m_in_rev, m_out_valid, m_out_ready, m_out_bit;
  logic [31:0] m_in_data;
  logic [4:0]  m_in_sel;

  bitsel_pipe #(.WIDTH(32), .LANES(1), .LVL_PER_STG(2)) u_main (
    .clk(clk), .rst(m_rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_data(m_in_data), .in_sel(m_in_sel), .in_rev(m_in_rev),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_bit(m_out_bit)
  );

  // Reference: three global-enable slots, index 2 is the output.
  logic m_mv [3];
  logic m_mb [3];
  logic m_got [$];

  task automatic m_clear();
    for (int i = 0; i < 3; i++) begin
      m_mv[i] = 1'b0;
      m_mb[i] = 1'b0;
    end
  endtask

  task automatic step_m(input logic iv, input logic [31:0] d, input logic [4:0] s,
                        input logic r, input logic ordy, output logic took);
    logic adv;
    int   idx;
    @(negedge clk);
    chk("main_out_valid", m_out_valid, m_mv[2]);
    if (m_mv[2]) chk("main_out_bit", m_out_bit, m_mb[2]);
    m_in_valid = iv; m_in_data = d; m_in_sel = s; m_in_rev = r; m_out_ready = ordy;
    #1;
    adv = ordy || !m_mv[2];
    chk("main_in_ready", m_in_ready, adv);
    if (m_out_valid && ordy) m_got.push_back(m_out_bit);
    took = iv && adv;
    if (adv) begin
      m_mv[2] = m_mv[1]; m_mb[2] = m_mb[1];
      m_mv[1] = m_mv[0]; m_mb[1] = m_mb[0];
      idx = r ? (31 - int'(s)) : int'(s);
      m_mv[0] = iv;
      m_mb[0] = d[idx];
    end
  endtask

  task automatic bp_run(input logic [31:0] d, input string tag);
    int   nxt;
    logic took;
    nxt = 0;
    m_got.delete();
    for (int t = 0; t < 40; t++) begin
      step_m(nxt < 8, d, 5'(nxt), 1'b0, !(t >= 4 && t <= 7), took);
      if (took) nxt++;
    end
    chk({tag, "_count"}, m_got.size(), 8);
    for (int k = 0; k < 8 && k < m_got.size(); k++) chk({tag, "_order"}, m_got[k], d[k]);
  endtask

  // ---------------- four-lane instance ----------------
  logic         l_rst, l_in_valid, l_in_ready, l_in_rev, l_out_valid, l_out_ready;
  logic [127:0] l_in_data;
  logic [19:0]  l_in_sel;
  logic [3:0]   l_out_bit;

  bitsel_pipe #(.WIDTH(32), .LANES(4), .LVL_PER_STG(2)) u_lanes (
    .clk(clk), .rst(l_rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_data(l_in_data), .in_sel(l_in_sel), .in_rev(l_in_rev),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_bit(l_out_bit)
  );

  task automatic l_beat(input logic [127:0] d, input logic [19:0] s, input logic r,
                        input logic [3:0] e, input string tag);
    @(negedge clk);
    l_in_valid = 1'b1; l_in_data = d; l_in_sel = s; l_in_rev = r; l_out_ready = 1'b1;
    #1 chk({tag, "_ready"}, l_in_ready, 1);
    @(negedge clk);
    l_in_valid = 1'b0;
    chk({tag, "_early1"}, l_out_valid, 0);
    @(negedge clk);
    chk({tag, "_early2"}, l_out_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, l_out_valid, 1);
    chk({tag, "_bits"}, l_out_bit, e);
  endtask

  // ---------------- parameter sweep ----------------
  localparam int NBEATS = 1000;
  logic rst_s;

  function automatic int sw_w(input int g);
    case (g)
      0:       return 2;
      1, 2:    return 8;
      default: return 64;
    endcase
  endfunction

  function automatic int sw_l(input int g);
    case (g)
      0, 1, 3: return 1;
      2, 4:    return 3;
      default: return 6;
    endcase
  endfunction

  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int W   = sw_w(g);
    localparam int LPS = sw_l(g);
    localparam int SW  = $clog2(W);
    localparam int STG = (SW + LPS - 1) / LPS;

    logic          in_valid, in_ready, in_rev, out_valid, out_ready, out_bit, done_f;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_sel;
    logic          mv [STG];
    logic          mb [STG];

    bitsel_pipe #(.WIDTH(W), .LANES(1), .LVL_PER_STG(LPS)) u_dut (
      .clk(clk), .rst(rst_s), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .in_rev(in_rev),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit)
    );

    initial begin : run
      int          acc, con, si, idx;
      logic        iv, ordy, rv, adv;
      logic [63:0] d64;
      done_f = 1'b0; acc = 0; con = 0;
      in_valid = 1'b0; in_data = '0; in_sel = '0; in_rev = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < STG; i++) begin
        mv[i] = 1'b0;
        mb[i] = 1'b0;
      end
      wait (sweep_go === 1'b1);
      for (int cyc = 0; cyc < 20000 && con < NBEATS; cyc++) begin
        @(negedge clk);
        chk($sformatf("sw%0d_valid", g), out_valid, mv[STG-1]);
        if (mv[STG-1]) chk($sformatf("sw%0d_bit", g), out_bit, mb[STG-1]);
        iv   = (acc < NBEATS) && ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
        rv   = 1'($urandom_range(0, 1));
        d64  = {$urandom(), $urandom()};
        si   = $urandom_range(0, W - 1);
        in_valid = iv; in_data = d64[W-1:0]; in_sel = SW'(si); in_rev = rv; out_ready = ordy;
        #1;
        adv = ordy || !mv[STG-1];
        chk($sformatf("sw%0d_ready", g), in_ready, adv);
        if (adv) begin
          if (mv[STG-1] && ordy) con++;
          for (int i = STG - 1; i > 0; i--) begin
            mv[i] = mv[i-1];
            mb[i] = mb[i-1];
          end
          idx   = rv ? (W - 1 - si) : si;
          mv[0] = iv;
          mb[0] = d64[idx];
          if (iv) acc++;
        end
      end
      chk($sformatf("sw%0d_consumed", g), con, NBEATS);
      done_f = 1'b1;
    end
  end

  logic all_done;
  assign all_done = g_sw[0].done_f & g_sw[1].done_f & g_sw[2].done_f &
                    g_sw[3].done_f & g_sw[4].done_f & g_sw[5].done_f;

  // ---------------- directed sequence ----------------
  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic        r;
    logic        e;
  } vec_t;

  vec_t tv [10];

  initial begin
    logic         took;
    logic [127:0] ld;
    logic [19:0]  ls;
    logic         lr;
    logic [3:0]   le;
    int           sk, ik;

    tv[0] = '{32'h8000_0001, 5'd0,  1'b0, 1'b1};
    tv[1] = '{32'h8000_0001, 5'd31, 1'b0, 1'b1};
    tv[2] = '{32'h8000_0001, 5'd5,  1'b0, 1'b0};
    tv[3] = '{32'h0000_0002, 5'd1,  1'b0, 1'b1};
    tv[4] = '{32'h0000_0002, 5'd30, 1'b1, 1'b1};
    tv[5] = '{32'h0000_0002, 5'd1,  1'b1, 1'b0};
    tv[6] = '{32'hFFFF_FFFE, 5'd0,  1'b0, 1'b0};
    tv[7] = '{32'hFFFF_FFFE, 5'd31, 1'b1, 1'b0};
    tv[8] = '{32'h0001_0000, 5'd16, 1'b0, 1'b1};
    tv[9] = '{32'h0001_0000, 5'd15, 1'b1, 1'b1};

    total = 0; bad = 0; sweep_go = 1'b0;
    m_rst = 1'b1; l_rst = 1'b1; rst_s = 1'b1;
    m_in_valid = 1'b0; m_in_data = '0; m_in_sel = '0; m_in_rev = 1'b0; m_out_ready = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_in_sel = '0; l_in_rev = 1'b0; l_out_ready = 1'b1;
    m_clear();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", m_out_valid, 0);
    chk("rst_out_bit", m_out_bit, 0);
    chk("rst_in_ready", m_in_ready, 0);
    chk("rst_lanes_bits", l_out_bit, 0);
    @(negedge clk);
    m_rst = 1'b0; l_rst = 1'b0; rst_s = 1'b0;
    #1;
    chk("post_rst_in_ready", m_in_ready, 1);
    chk("post_rst_lanes_ready", l_in_ready, 1);

    // Single beats: latency of exactly three cycles and the selected bit.
    for (int i = 0; i < 10; i++) begin
      step_m(1'b1, tv[i].d, tv[i].s, tv[i].r, 1'b1, took);
      for (int c = 0; c < 3; c++) step_m(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, took);
      chk($sformatf("tbl%0d_valid", i), m_out_valid, 1);
      chk($sformatf("tbl%0d_bit", i), m_out_bit, tv[i].e);
    end

    // Back-pressure: eight streamed beats with a four-cycle downstream stall.
    bp_run(32'h0000_00FF, "bp_ff");
    bp_run(32'h0000_0055, "bp_55");

    // Reset with three beats in flight.
    for (int b = 0; b < 3; b++) step_m(1'b1, 32'hFFFF_FFFF, 5'(b), 1'b0, 1'b1, took);
    step_m(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, took);
    #2;
    m_rst = 1'b1; m_in_valid = 1'b0; m_out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", m_out_valid, 0);
    chk("midrst_out_bit", m_out_bit, 0);
    chk("midrst_in_ready", m_in_ready, 0);
    m_clear();
    @(negedge clk);
    m_rst = 1'b0;
    #1 chk("midrst_release_ready", m_in_ready, 1);
    for (int c = 0; c < 4; c++) step_m(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, took);
    step_m(1'b1, 32'h0000_0001, 5'd0, 1'b0, 1'b1, took);
    for (int c = 0; c < 3; c++) step_m(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, took);
    chk("midrst_new_valid", m_out_valid, 1);
    chk("midrst_new_bit", m_out_bit, 1);

    // Four lanes.
    l_beat({32'h8, 32'h4, 32'h2, 32'h1}, {5'd3, 5'd2, 5'd1, 5'd0}, 1'b0, 4'b1111, "lanes_k");
    l_beat({32'h8, 32'h4, 32'h2, 32'h1}, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0, 4'b0000, "lanes_k1");
    l_beat({32'h8, 32'h4, 32'h2, 32'h1}, {5'd28, 5'd29, 5'd30, 5'd31}, 1'b1, 4'b1111, "lanes_rev");
    for (int v = 0; v < 6; v++) begin
      ld = {$urandom(), $urandom(), $urandom(), $urandom()};
      ls = 20'($urandom());
      lr = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        sk    = int'(ls[k*5 +: 5]);
        ik    = lr ? (31 - sk) : sk;
        le[k] = ld[k*32 + ik];
      end
      l_beat(ld, ls, lr, le, $sformatf("lanes_rnd%0d", v));
    end

    // Parameter sweep runs in its own processes.
    sweep_go = 1'b1;
    for (int w = 0; w < 40000 && !all_done; w++) @(negedge clk);
    chk("sweep_done", all_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
